// File: rtl/sdram_sched_pkg.sv
// Shared state encoding and address-field layout for the SDRAM page scheduler.
package sdram_sched_pkg;

   localparam int ROW_W   = 13;
   localparam int COL_W   = 9;
   localparam int ROW_LSB = 11;
   localparam int ROW_MSB = ROW_LSB + ROW_W - 1;
   localparam int COL_LSB = 2;
   localparam int COL_MSB = COL_LSB + COL_W - 1;
   localparam int WAIT_W  = 16;

   typedef enum logic [3:0] {
      S_IDLE,
      S_PCH,
      S_PCH_WAIT,
      S_ACT,
      S_ACT_WAIT,
      S_ACCESS,
      S_DATA_WAIT,
      S_REF,
      S_REF_WAIT
   } sched_state_e;

   function automatic logic [ROW_W-1:0] col_caddr(input logic [COL_W-1:0] col);
      return {{(ROW_W - COL_W){1'b0}}, col};
   endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter with a sticky due flag.
module sdram_refresh_timer #(
   parameter int INTERVAL = 780
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic due_o
);

   localparam int            CW   = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
   localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          due_q;
   logic          due_d;
   logic          wrap;

   // A wrap landing on the clear cycle wins, so no interval is dropped.
   always_comb begin
      wrap  = (cnt_q == LAST);
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
      due_d = wrap | (due_q & ~clr_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         due_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         due_q <= due_d;
      end
   end

   assign due_o = due_q;

endmodule

// File: rtl/sdram_page_sched.sv
// Open-page SDRAM command scheduler; define SDRAM_SCHED_CLOSED_PAGE_EN
// to precharge after every access instead.
module sdram_page_sched
   import sdram_sched_pkg::*;
#(
   parameter int REFRESH_INTERVAL = 780,
   parameter int ACT_WAIT         = 3,
   parameter int PCH_WAIT         = 3,
   parameter int REF_WAIT         = 10
) (
   input  logic        clk,
   input  logic        init,
   input  logic [26:1] cpu_addr,
   input  logic        cpu_req,
   input  logic        cpu_rnw,
   input  logic [31:0] cpu_din,
   input  logic [3:0]  cpu_be,
   output logic [31:0] cpu_dout,
   output logic        cpu_ready,
   output logic        cpu_busy,
   output logic [12:0] ch1_caddr,
   output logic        ch1_req,
   output logic        ch1_ref,
   output logic        ch1_act,
   output logic        ch1_pch,
   output logic        ch1_rnw,
   output logic [31:0] ch1_din,
   output logic [3:0]  ch1_be,
   input  logic [31:0] ch1_dout,
   input  logic        ch1_ready
);

`ifdef SDRAM_SCHED_CLOSED_PAGE_EN
   localparam bit CLOSED_PAGE = 1'b1;
`else
   localparam bit CLOSED_PAGE = 1'b0;
`endif

   localparam logic [WAIT_W-1:0] ACT_LD = WAIT_W'((ACT_WAIT > 0) ? ACT_WAIT - 1 : 0);
   localparam logic [WAIT_W-1:0] PCH_LD = WAIT_W'((PCH_WAIT > 0) ? PCH_WAIT - 1 : 0);
   localparam logic [WAIT_W-1:0] REF_LD = WAIT_W'((REF_WAIT > 0) ? REF_WAIT - 1 : 0);

   sched_state_e      state_q, state_d;
   sched_state_e      pch_exit;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              busy_q, busy_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic              rnw_q, rnw_d;
   logic [31:0]       din_q, din_d;
   logic [3:0]        be_q, be_d;
   logic              row_open_q, row_open_d;
   logic [ROW_W-1:0]  open_row_q, open_row_d;
   logic [31:0]       dout_q, dout_d;
   logic              ready_q, ready_d;
   logic [ROW_W-1:0]  caddr_q, caddr_d;
   logic              req_q, req_d;
   logic              ref_q, ref_d;
   logic              act_q, act_d;
   logic              pch_q, pch_d;
   logic              accept;
   logic              row_hit;
   logic              ref_due;
   logic              ref_clr;
   logic              unused_addr;

   assign unused_addr = ^{cpu_addr[26:24], cpu_addr[1]};

   sdram_refresh_timer #(
      .INTERVAL (REFRESH_INTERVAL)
   ) u_refresh_timer (
      .clk_i (clk),
      .rst_i (init),
      .clr_i (ref_clr),
      .due_o (ref_due)
   );

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      busy_d     = busy_q;
      row_d      = row_q;
      col_d      = col_q;
      rnw_d      = rnw_q;
      din_d      = din_q;
      be_d       = be_q;
      row_open_d = row_open_q;
      open_row_d = open_row_q;
      dout_d     = dout_q;
      ready_d    = 1'b0;
      caddr_d    = caddr_q;
      ref_clr    = 1'b0;
      accept     = cpu_req & ~busy_q;
      row_hit    = row_open_q & (open_row_q == row_q);
      pch_exit   = ref_due ? S_REF : (busy_q ? S_ACT : S_IDLE);

      if (accept) begin
         busy_d = 1'b1;
         row_d  = cpu_addr[ROW_MSB:ROW_LSB];
         col_d  = cpu_addr[COL_MSB:COL_LSB];
         rnw_d  = cpu_rnw;
         din_d  = cpu_din;
         be_d   = cpu_be;
      end

      unique case (state_q)
         S_IDLE: begin
            if (ref_due) begin
               state_d = row_open_q ? S_PCH : S_REF;
            end else if (busy_q) begin
               if (row_hit)         state_d = S_ACCESS;
               else if (row_open_q) state_d = S_PCH;
               else                 state_d = S_ACT;
            end
         end
         S_PCH: begin
            wait_d  = PCH_LD;
            state_d = (PCH_WAIT > 0) ? S_PCH_WAIT : pch_exit;
         end
         S_PCH_WAIT: begin
            if (wait_q == '0) state_d = pch_exit;
            else              wait_d  = wait_q - WAIT_W'(1);
         end
         S_ACT: begin
            wait_d  = ACT_LD;
            state_d = (ACT_WAIT > 0) ? S_ACT_WAIT : S_ACCESS;
         end
         S_ACT_WAIT: begin
            if (wait_q == '0) state_d = S_ACCESS;
            else              wait_d  = wait_q - WAIT_W'(1);
         end
         S_ACCESS: begin
            state_d = S_DATA_WAIT;
         end
         S_DATA_WAIT: begin
            if (ch1_ready) begin
               if (rnw_q) dout_d = ch1_dout;
               ready_d = 1'b1;
               busy_d  = 1'b0;
               state_d = CLOSED_PAGE ? S_PCH : S_IDLE;
            end
         end
         S_REF: begin
            wait_d  = REF_LD;
            ref_clr = (REF_WAIT == 0);
            state_d = (REF_WAIT > 0) ? S_REF_WAIT : S_IDLE;
         end
         S_REF_WAIT: begin
            if (wait_q == '0) begin
               ref_clr = 1'b1;
               state_d = S_IDLE;
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Strobes and the row mirror follow the state being entered.
      if (state_d == S_ACT) begin
         row_open_d = 1'b1;
         open_row_d = row_q;
         caddr_d    = row_q;
      end
      if (state_d == S_PCH)    row_open_d = 1'b0;
      if (state_d == S_ACCESS) caddr_d    = col_caddr(col_q);

      req_d = (state_d == S_ACCESS);
      ref_d = (state_d == S_REF);
      act_d = (state_d == S_ACT);
      pch_d = (state_d == S_PCH);
   end

   always_ff @(posedge clk) begin
      if (init) begin
         state_q    <= S_IDLE;
         wait_q     <= '0;
         busy_q     <= 1'b0;
         row_q      <= '0;
         col_q      <= '0;
         rnw_q      <= 1'b0;
         din_q      <= '0;
         be_q       <= '0;
         row_open_q <= 1'b0;
         open_row_q <= '0;
         dout_q     <= '0;
         ready_q    <= 1'b0;
         caddr_q    <= '0;
         req_q      <= 1'b0;
         ref_q      <= 1'b0;
         act_q      <= 1'b0;
         pch_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         busy_q     <= busy_d;
         row_q      <= row_d;
         col_q      <= col_d;
         rnw_q      <= rnw_d;
         din_q      <= din_d;
         be_q       <= be_d;
         row_open_q <= row_open_d;
         open_row_q <= open_row_d;
         dout_q     <= dout_d;
         ready_q    <= ready_d;
         caddr_q    <= caddr_d;
         req_q      <= req_d;
         ref_q      <= ref_d;
         act_q      <= act_d;
         pch_q      <= pch_d;
      end
   end

   assign cpu_dout  = dout_q;
   assign cpu_ready = ready_q;
   assign cpu_busy  = busy_q;
   assign ch1_caddr = caddr_q;
   assign ch1_req   = req_q;
   assign ch1_ref   = ref_q;
   assign ch1_act   = act_q;
   assign ch1_pch   = pch_q;
   assign ch1_rnw   = rnw_q;
   assign ch1_din   = din_q;
   assign ch1_be    = be_q;

endmodule

// File: tb/tb_sdram_page_sched.sv
// Randomised bench for sdram_page_sched against a transaction-level model.
module tb_sdram_page_sched;

   localparam int RI = 780;
   localparam int AW = 3;
   localparam int PW = 3;
   localparam int RW = 10;

   logic        clk = 1'b0;
   logic        init = 1'b1;
   logic [26:1] cpu_addr = '0;
   logic        cpu_req = 1'b0;
   logic        cpu_rnw = 1'b0;
   logic [31:0] cpu_din = '0;
   logic [3:0]  cpu_be = '0;
   logic [31:0] cpu_dout;
   logic        cpu_ready;
   logic        cpu_busy;
   logic [12:0] ch1_caddr;
   logic        ch1_req;
   logic        ch1_ref;
   logic        ch1_act;
   logic        ch1_pch;
   logic        ch1_rnw;
   logic [31:0] ch1_din;
   logic [3:0]  ch1_be;
   logic [31:0] ch1_dout = '0;
   logic        ch1_ready = 1'b0;

   always #5 clk = ~clk;

   sdram_page_sched #(
      .REFRESH_INTERVAL (RI),
      .ACT_WAIT         (AW),
      .PCH_WAIT         (PW),
      .REF_WAIT         (RW)
   ) dut (
      .clk       (clk),
      .init      (init),
      .cpu_addr  (cpu_addr),
      .cpu_req   (cpu_req),
      .cpu_rnw   (cpu_rnw),
      .cpu_din   (cpu_din),
      .cpu_be    (cpu_be),
      .cpu_dout  (cpu_dout),
      .cpu_ready (cpu_ready),
      .cpu_busy  (cpu_busy),
      .ch1_caddr (ch1_caddr),
      .ch1_req   (ch1_req),
      .ch1_ref   (ch1_ref),
      .ch1_act   (ch1_act),
      .ch1_pch   (ch1_pch),
      .ch1_rnw   (ch1_rnw),
      .ch1_din   (ch1_din),
      .ch1_be    (ch1_be),
      .ch1_dout  (ch1_dout),
      .ch1_ready (ch1_ready)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [95:0] outs();
      return {8'h0, cpu_dout, cpu_ready, cpu_busy, ch1_caddr, ch1_req, ch1_ref,
              ch1_act, ch1_pch, ch1_rnw, ch1_din, ch1_be};
   endfunction

   // Model state: open row, refresh obligation, command tallies.
   int          cyc = 0;
   int          k = 0;
   bit          m_due = 1'b0;
   bit          m_open = 1'b0;
   logic [12:0] m_row = '0;
   int          pch_cnt = 0, act_cnt = 0, ref_cnt = 0, req_cnt = 0, rdy_cnt = 0;
   int          act_cyc = 0, ref_cyc = 0;
   logic [12:0] act_caddr = '0;
   int          last_stb = 0;
   int          last_cyc = 0;

   always @(negedge clk) begin
      int nstb;
      cyc++;
      if (init) begin
         k = 0;
         m_due = 1'b0;
         m_open = 1'b0;
         last_stb = 0;
      end else begin
         k++;
         if (k % RI == 0) m_due = 1'b1;
         nstb = ch1_req + ch1_ref + ch1_act + ch1_pch;
         if (nstb != 0) begin
            check("one_strobe", nstb, 1);
            if (last_stb == 1) check("pch_gap", (cyc - last_cyc) >= PW + 1, 1);
            if (last_stb == 2) check("act_gap", cyc - last_cyc, AW + 1);
            if (last_stb == 3) check("ref_gap", (cyc - last_cyc) >= RW + 1, 1);
            last_cyc = cyc;
         end
         if (ch1_pch) begin
            pch_cnt++;
            m_open = 1'b0;
            last_stb = 1;
         end
         if (ch1_act) begin
            check("act_closed", m_open, 0);
            act_cnt++;
            m_open = 1'b1;
            m_row = ch1_caddr;
            act_caddr = ch1_caddr;
            act_cyc = cyc;
            last_stb = 2;
         end
         if (ch1_ref) begin
            check("ref_due", m_due, 1);
            check("ref_closed", m_open, 0);
            ref_cnt++;
            m_due = 1'b0;
            ref_cyc = cyc;
            last_stb = 3;
         end
         if (ch1_req) begin
            check("req_open", m_open, 1);
            req_cnt++;
            last_stb = 4;
         end
         if (cpu_ready) rdy_cnt++;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic txn(input logic [31:0] ba, input logic rnw, input logic [31:0] d,
                      input logic [3:0] be, input int dly, input logic [31:0] rd,
                      input bit poke);
      int          p0, a0, r0, lat;
      bit          open0, hit, refd, e_act, e_pch;
      logic [31:0] dout0;
      p0    = pch_cnt;
      a0    = act_cnt;
      r0    = ref_cnt;
      open0 = m_open;
      hit   = m_open && (m_row == ba[23:11]);
      dout0 = cpu_dout;
      cpu_addr = ba[26:1];
      cpu_rnw  = rnw;
      cpu_din  = d;
      cpu_be   = be;
      cpu_req  = 1'b1;
      step();
      lat = 1;
      check("busy_set", cpu_busy, 1);
      if (poke) begin
         cpu_addr = ~ba[26:1];
         cpu_rnw  = ~rnw;
         cpu_din  = ~d;
         cpu_be   = ~be;
      end else begin
         cpu_req = 1'b0;
      end
      while (!ch1_req && lat < 400) begin
         step();
         cpu_req = 1'b0;
         lat++;
      end
      cpu_req = 1'b0;
      if (!ch1_req) begin
         check("req_timeout", 0, 1);
         return;
      end
      refd  = (ref_cnt != r0);
      e_act = refd || !hit;
      e_pch = open0 && e_act;
      check("act_cnt", act_cnt - a0, e_act);
      check("pch_cnt", pch_cnt - p0, e_pch);
      if (e_act) check("act_row", act_caddr, ba[23:11]);
      check("req_col", ch1_caddr, {4'b0, ba[10:2]});
      check("req_rnw", ch1_rnw, rnw);
      if (!rnw) check("req_wdata", {ch1_be, ch1_din}, {be, d});
      if (hit && !refd) check("hit_lat", lat, 2);
      repeat (dly) step();
      ch1_dout  = rd;
      ch1_ready = 1'b1;
      step();
      ch1_ready = 1'b0;
      ch1_dout  = $urandom;
      check("cpu_ready", cpu_ready, 1);
      check("cpu_dout", cpu_dout, rnw ? rd : dout0);
      check("busy_clr", cpu_busy, 0);
      step();
      check("ready_pulse", cpu_ready, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          p0, r0, a0, q0, y0, n;
      bit          open0;
      logic [31:0] ba;

      repeat (3) step();
      check("rst_outs", outs(), 0);
      init = 1'b0;
      step();

      txn(32'h0000_0800, 1'b1, 32'h0, 4'h0, 2, 32'hDEAD_BEEF, 1'b0);
      check("first_dout", cpu_dout, 32'hDEAD_BEEF);
      txn(32'h0000_0804, 1'b1, 32'h0, 4'h0, 1, 32'h0BAD_CAFE, 1'b0);
      txn(32'h0000_1000, 1'b0, 32'h1234_5678, 4'b0011, 3, 32'h5555_AAAA, 1'b0);

      p0 = pch_cnt;
      r0 = ref_cnt;
      open0 = m_open;
      repeat (800) step();
      check("idle_pch", pch_cnt - p0, open0);
      check("idle_ref", ref_cnt - r0, 1);
      a0 = act_cnt;
      txn(32'h0000_1000, 1'b1, 32'h0, 4'h0, 1, 32'h1111_2222, 1'b0);
      check("react", act_cnt - a0, 1);

      n = 0;
      while (!m_due && n < 2 * RI) begin
         step();
         n++;
      end
      check("due_seen", m_due, 1);
      r0 = ref_cnt;
      txn(32'h0000_3004, 1'b1, 32'h0, 4'h0, 2, 32'h7777_8888, 1'b1);
      check("ref_first", ref_cnt - r0, 1);
      check("ref_before_act", ref_cyc < act_cyc, 1);
      q0 = req_cnt;
      repeat (30) step();
      check("drop_busy_req", req_cnt - q0, 0);

      ba = 32'h0000_2000;
      cpu_addr = ba[26:1];
      cpu_rnw  = 1'b1;
      cpu_req  = 1'b1;
      step();
      cpu_req = 1'b0;
      n = 0;
      while (!ch1_req && n < 50) begin
         step();
         n++;
      end
      check("init_req_seen", ch1_req, 1);
      step();
      y0 = rdy_cnt;
      init      = 1'b1;
      ch1_ready = 1'b1;
      ch1_dout  = 32'hCAFE_F00D;
      step();
      check("init_outs", outs(), 0);
      ch1_ready = 1'b0;
      step();
      check("init_outs2", outs(), 0);
      init = 1'b0;
      step();
      check("init_no_ready", cpu_ready, 0);
      check("init_no_ready_cnt", rdy_cnt - y0, 0);
      txn(32'h0000_2000, 1'b1, 32'h0, 4'h0, 1, 32'h0F0F_F0F0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         ba = {5'b0, 3'($urandom), 13'($urandom_range(0, 3)), 9'($urandom), 2'($urandom)};
         txn(ba, 1'($urandom), $urandom, 4'($urandom), $urandom_range(1, 6),
             $urandom, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 40)) step();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sdram_page_sched.md
SDRAM_PAGE_SCHED -- requirements
Module: sdram_page_sched

Interface
REQ-001 SHALL have parameter REFRESH_INTERVAL, default 780; clocks between refresh requests.
REQ-002 SHALL have parameter ACT_WAIT, default 3; clocks held after an activate pulse before the next command.
REQ-003 SHALL have parameter PCH_WAIT, default 3; clocks held after a precharge pulse.
REQ-004 SHALL have parameter REF_WAIT, default 10; clocks held after a refresh pulse.
REQ-005 Ports: clk  in  1  single clock; all logic on posedge. Reset is synchronous and active-high.
REQ-006 Ports: init  in  1  synchronous active-high reset.
REQ-007 Ports: cpu_addr  in  26 [26:1]  byte address; row = [23:11], column word = [10:2].
REQ-008 Ports: cpu_req  in  1  one-cycle request strobe; cpu_rnw  in  1  1=read.
REQ-009 Ports: cpu_din  in  32  write data; cpu_be  in  4  byte enables.
REQ-010 Ports: cpu_dout  out  32  read data; cpu_ready  out  1  one-cycle completion pulse.
REQ-011 Ports: cpu_busy  out  1  high from accepted request until cpu_ready.
REQ-012 Ports: ch1_caddr  out  13  row (activate) or {4'b0, column} (access).
REQ-013 Ports: ch1_req / ch1_ref / ch1_act / ch1_pch  out  1 each  one-cycle strobes to the SDRAM controller.
REQ-014 Ports: ch1_rnw  out  1; ch1_din  out  32; ch1_be  out  4  registered copies of the accepted request.
REQ-015 Ports: ch1_dout  in  32; ch1_ready  in  1  completion from the controller.

Function
REQ-016 SHALL capture addr/rnw/din/be on cpu_req while not busy; cpu_req while busy SHALL be ignored.
REQ-017 SHALL track row_open (1 bit) and open_row (13 bits) mirroring the controller's open row.
REQ-018 FSM states SHALL be IDLE, PCH, PCH_WAIT, ACT, ACT_WAIT, ACCESS, DATA_WAIT, REF, REF_WAIT.
REQ-019 IDLE: refresh_due SHALL take priority; if row_open go PCH, else go REF.
REQ-020 IDLE with a pending request: row hit -> ACCESS; row_open with a different row -> PCH; no row open -> ACT.
REQ-021 PCH SHALL pulse ch1_pch for 1 clock, clear row_open, then wait PCH_WAIT clocks, then go to REF if refresh_due, else ACT.
REQ-022 ACT SHALL pulse ch1_act with ch1_caddr=row, set row_open and open_row, wait ACT_WAIT clocks, then go ACCESS.
REQ-023 ACCESS SHALL pulse ch1_req with ch1_caddr={4'b0,column} for 1 clock, then go DATA_WAIT.
REQ-024 DATA_WAIT: on ch1_ready, SHALL latch ch1_dout into cpu_dout (reads only), pulse cpu_ready the next clock, clear busy, and return to IDLE.
REQ-025 REF SHALL pulse ch1_ref, wait REF_WAIT clocks, clear refresh_due, and return to IDLE.
REQ-026 Refresh counter SHALL count up from 0 and set refresh_due at REFRESH_INTERVAL-1, then wrap to 0; a pending refresh_due SHALL NOT be lost if the counter wraps again before service.
REQ-027 No two ch1_* strobes SHALL ever be asserted in the same clock.
REQ-028 A refresh that becomes due during an access SHALL be serviced only after cpu_ready and before the next request.
REQ-029 Minimum read latency on a row hit SHALL be cpu_req -> ch1_req in 2 clocks.

Reset
REQ-030 While init is high, all outputs SHALL be 0, cpu_dout SHALL be 0, row_open SHALL be 0, refresh_due SHALL be 0, the counter SHALL be 0, and the FSM SHALL be in IDLE.
REQ-031 init asserted mid-operation SHALL abandon the transaction without a cpu_ready pulse; the first post-reset access SHALL activate the row.

Configuration
REQ-032 With SDRAM_SCHED_CLOSED_PAGE_EN defined, every access SHALL be followed by PCH (after cpu_ready), so row_open is 0 in IDLE.
REQ-033 Without SDRAM_SCHED_CLOSED_PAGE_EN defined, the policy SHALL be open-page per REQ-020.

Structure
REQ-034 Package sdram_sched_pkg SHALL hold the FSM state enum, row/column width constants, and the address-field slice positions.
REQ-035 Sub-module sdram_refresh_timer (counter plus sticky due flag, clear input) SHALL be instantiated once.

Verification
REQ-036 Reset, then read 0x0000_0800 -> ch1_act with caddr=0x001, then after ACT_WAIT ch1_req with caddr=0x000; ch1_dout=0xDEADBEEF returned -> cpu_dout=0xDEADBEEF plus a cpu_ready pulse.
REQ-037 Second read 0x0000_0804 (same row) -> no ch1_act; ch1_req 2 clocks after cpu_req with caddr=0x001.
REQ-038 Write 0x0000_1000, din=0x12345678, be=4'b0011 (row 0x002, open row 0x001) -> ch1_pch, ch1_act caddr=0x002, ch1_req, ch1_rnw=0, ch1_din/be match.
REQ-039 Idle for 780 clocks with a row open -> ch1_pch then ch1_ref; the next access re-activates the row.
REQ-040 cpu_req issued while refresh_due is set -> the refresh completes before ch1_act for the request; cpu_req while busy is dropped.
REQ-041 init pulsed during DATA_WAIT -> no cpu_ready pulse and all outputs 0; the next read issues ch1_act.
